// File: rtl/rv32i_regfile_sb.sv
// rv32i_regfile_sb: RV32I integer register file with same-cycle write-back
// bypass and a per-register pending-write scoreboard for RAW hazard stalls.
// x0 is hard-wired to zero and is never pending.
module rv32i_regfile_sb #(
    parameter int              XLEN        = 32,
    parameter int              NUM_REGS    = 32,
    parameter logic [XLEN-1:0] RESET_VALUE = {XLEN{1'b0}},
    localparam int             IDX_W       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_enable,
    input  logic [IDX_W-1:0] wb_reg,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             issue_valid,
    input  logic [IDX_W-1:0] issue_rd,
    input  logic [IDX_W-1:0] rs1_reg,
    input  logic [IDX_W-1:0] rs2_reg,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             rs1_ready,
    output logic             rs2_ready,
    output logic             stall,
    output logic             wb_orphan
);

    logic [XLEN-1:0]     regs_r [0:NUM_REGS-1];
    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] pending_next_s;
    logic                wb_orphan_r;
    logic                wb_write_s;
    logic                issue_set_s;
    logic                orphan_set_s;
    logic                bypass1_s;
    logic                bypass2_s;

    // Qualify write-back and issue strobes; x0 never takes part in either.
    always_comb begin
        wb_write_s   = 1'b0;
        issue_set_s  = 1'b0;
        orphan_set_s = 1'b0;
        if (wb_enable && (wb_reg != {IDX_W{1'b0}})) begin
            wb_write_s   = 1'b1;
            orphan_set_s = ~pending_r[wb_reg];
        end else begin
            wb_write_s   = 1'b0;
            orphan_set_s = 1'b0;
        end
        if (issue_valid && (issue_rd != {IDX_W{1'b0}})) begin
            issue_set_s = 1'b1;
        end else begin
            issue_set_s = 1'b0;
        end
    end

    // Next scoreboard state: write-back clears, issue sets afterwards so a
    // same-index issue (newer producer) wins over the write-back.
    always_comb begin
        pending_next_s = pending_r;
        if (wb_write_s) begin
            pending_next_s[wb_reg] = 1'b0;
        end else begin
            pending_next_s = pending_r;
        end
        if (issue_set_s) begin
            pending_next_s[issue_rd] = 1'b1;
        end else begin
            pending_next_s[issue_rd] = pending_next_s[issue_rd];
        end
        pending_next_s[0] = 1'b0;
    end

    // Register array storage; write-back updates one entry per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VALUE;
            end
        end else if (wb_write_s) begin
            regs_r[wb_reg] <= wb_data;
        end
    end

    // Scoreboard and sticky orphan flag; reset discards all outstanding writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r   <= {NUM_REGS{1'b0}};
            wb_orphan_r <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            if (orphan_set_s) begin
                wb_orphan_r <= 1'b1;
            end
        end
    end

    // Bypass is suppressed while reset is held so reads show reset values.
    always_comb begin
        bypass1_s = reset & wb_write_s & (wb_reg == rs1_reg);
        bypass2_s = reset & wb_write_s & (wb_reg == rs2_reg);
    end

    // Read port 1: x0 reads zero, otherwise bypass or array value.
    always_comb begin
        rs1_data  = {XLEN{1'b0}};
        rs1_ready = 1'b1;
        if (rs1_reg == {IDX_W{1'b0}}) begin
            rs1_data  = {XLEN{1'b0}};
            rs1_ready = 1'b1;
        end else if (bypass1_s) begin
            rs1_data  = wb_data;
            rs1_ready = 1'b1;
        end else begin
            rs1_data  = regs_r[rs1_reg];
            rs1_ready = ~pending_r[rs1_reg];
        end
    end

    // Read port 2: identical to port 1 and fully independent of it.
    always_comb begin
        rs2_data  = {XLEN{1'b0}};
        rs2_ready = 1'b1;
        if (rs2_reg == {IDX_W{1'b0}}) begin
            rs2_data  = {XLEN{1'b0}};
            rs2_ready = 1'b1;
        end else if (bypass2_s) begin
            rs2_data  = wb_data;
            rs2_ready = 1'b1;
        end else begin
            rs2_data  = regs_r[rs2_reg];
            rs2_ready = ~pending_r[rs2_reg];
        end
    end

    // Decode stalls whenever either source operand is not yet current.
    always_comb begin
        stall     = ~(rs1_ready & rs2_ready);
        wb_orphan = wb_orphan_r;
    end

endmodule

// File: tb/tb_rv32i_regfile_sb.sv
// Directed self-checking bench for rv32i_regfile_sb. Inputs change on the
// falling edge; combinational outputs are checked 1ns later.
module tb_rv32i_regfile_sb;

    logic        clk;
    logic        reset;
    logic        wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_reg;
    logic [4:0]  rs2_reg;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_ready;
    logic        rs2_ready;
    logic        stall;
    logic        wb_orphan;

    int n_cmp;
    int n_bad;

    rv32i_regfile_sb dut (
        .clk(clk), .reset(reset),
        .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_reg(rs1_reg), .rs2_reg(rs2_reg),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .stall(stall), .wb_orphan(wb_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge (one posedge passes) and clear strobes.
    task automatic next_cycle();
        @(negedge clk);
        wb_enable   = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; wb_enable = 1'b1; wb_reg = 5'd5; wb_data = 32'hABC;
        issue_valid = 1'b1; issue_rd = 5'd5; rs1_reg = 5'd5; rs2_reg = 5'd0;
        @(negedge clk); #1;
        n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL in_reset_data got %h want %h", rs1_data, 32'h0); end
        n_cmp++; if (rs1_ready !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL in_reset_ready got %b/%b want 1/0", rs1_ready, stall); end
        next_cycle();
        reset = 1'b1; #1;
        n_cmp++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h/%h want 0/0", rs1_data, rs2_data); end
        n_cmp++; if (rs1_ready !== 1'b1 || rs2_ready !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b%b%b want 110", rs1_ready, rs2_ready, stall); end
        n_cmp++; if (wb_orphan !== 1'b0) begin n_bad++; $display("FAIL reset_orphan got %b want 0", wb_orphan); end
    endtask

    task automatic test_issue_bypass();
        next_cycle();
        issue_valid = 1'b1; issue_rd = 5'd10; rs1_reg = 5'd10; rs2_reg = 5'd0; #1;
        n_cmp++; if (rs1_ready !== 1'b1) begin n_bad++; $display("FAIL self_src_ready got %b want 1", rs1_ready); end
        next_cycle(); #1;
        n_cmp++; if (rs1_ready !== 1'b0 || stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall got ready %b stall %b want 0 1", rs1_ready, stall); end
        wb_enable = 1'b1; wb_reg = 5'd10; wb_data = 32'h25; #1;
        n_cmp++; if (rs1_data !== 32'h25 || rs1_ready !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL bypass got %h %b %b want 25 1 0", rs1_data, rs1_ready, stall); end
        next_cycle(); #1;
        n_cmp++; if (rs1_data !== 32'h25 || rs1_ready !== 1'b1) begin n_bad++; $display("FAIL after_wb got %h %b want 25 1", rs1_data, rs1_ready); end
        n_cmp++; if (wb_orphan !== 1'b0) begin n_bad++; $display("FAIL no_orphan got %b want 0", wb_orphan); end
    endtask

    task automatic test_x0();
        next_cycle();
        rs1_reg = 5'd0; wb_enable = 1'b1; wb_reg = 5'd0; wb_data = 32'd321; #1;
        n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL x0_bypass got %h want 0", rs1_data); end
        next_cycle();
        issue_valid = 1'b1; issue_rd = 5'd0; #1;
        n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL x0_after_wb got %h want 0", rs1_data); end
        next_cycle(); #1;
        n_cmp++; if (rs1_ready !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL x0_issue got %b %b want 1 0", rs1_ready, stall); end
        n_cmp++; if (wb_orphan !== 1'b0) begin n_bad++; $display("FAIL x0_orphan got %b want 0", wb_orphan); end
    endtask

    task automatic test_same_edge();
        next_cycle();
        issue_valid = 1'b1; issue_rd = 5'd3; rs1_reg = 5'd3;
        next_cycle();
        issue_valid = 1'b1; issue_rd = 5'd3; wb_enable = 1'b1; wb_reg = 5'd3; wb_data = 32'd5; #1;
        n_cmp++; if (rs1_data !== 32'd5 || rs1_ready !== 1'b1) begin n_bad++; $display("FAIL same_edge_bypass got %h %b want 5 1", rs1_data, rs1_ready); end
        next_cycle(); #1;
        n_cmp++; if (rs1_data !== 32'd5 || rs1_ready !== 1'b0 || stall !== 1'b1) begin n_bad++; $display("FAIL issue_wins got %h %b %b want 5 0 1", rs1_data, rs1_ready, stall); end
        n_cmp++; if (wb_orphan !== 1'b0) begin n_bad++; $display("FAIL same_edge_orphan got %b want 0", wb_orphan); end
        wb_enable = 1'b1; wb_reg = 5'd3; wb_data = 32'd6;
        next_cycle(); #1;
        n_cmp++; if (rs1_data !== 32'd6 || rs1_ready !== 1'b1) begin n_bad++; $display("FAIL second_wb got %h %b want 6 1", rs1_data, rs1_ready); end
    endtask

    task automatic test_reissue_dual();
        next_cycle();
        issue_valid = 1'b1; issue_rd = 5'd12; rs1_reg = 5'd12; rs2_reg = 5'd12;
        next_cycle();
        issue_valid = 1'b1; issue_rd = 5'd12;
        next_cycle(); #1;
        n_cmp++; if (rs1_ready !== 1'b0 || rs2_ready !== 1'b0) begin n_bad++; $display("FAIL reissue_pending got %b %b want 0 0", rs1_ready, rs2_ready); end
        wb_enable = 1'b1; wb_reg = 5'd12; wb_data = 32'hDEAD_BEEF;
        next_cycle(); #1;
        n_cmp++; if (rs1_ready !== 1'b1 || rs2_ready !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL one_wb_clears got %b %b %b want 1 1 0", rs1_ready, rs2_ready, stall); end
        n_cmp++; if (rs1_data !== 32'hDEAD_BEEF || rs2_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL dual_port got %h %h want deadbeef", rs1_data, rs2_data); end
        rs1_reg = 5'd10; #1;
        n_cmp++; if (rs1_data !== 32'h25 || rs2_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ports_indep got %h %h want 25 deadbeef", rs1_data, rs2_data); end
    endtask

    task automatic test_orphan();
        next_cycle();
        wb_enable = 1'b1; wb_reg = 5'd7; wb_data = 32'h20; rs2_reg = 5'd7;
        next_cycle(); #1;
        n_cmp++; if (rs2_data !== 32'h20 || rs2_ready !== 1'b1) begin n_bad++; $display("FAIL orphan_data got %h %b want 20 1", rs2_data, rs2_ready); end
        n_cmp++; if (wb_orphan !== 1'b1) begin n_bad++; $display("FAIL orphan_set got %b want 1", wb_orphan); end
        next_cycle(); next_cycle(); #1;
        n_cmp++; if (wb_orphan !== 1'b1) begin n_bad++; $display("FAIL orphan_sticky got %b want 1", wb_orphan); end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        issue_valid = 1'b1; issue_rd = 5'd4;
        next_cycle();
        issue_valid = 1'b1; issue_rd = 5'd9; rs1_reg = 5'd4; rs2_reg = 5'd9;
        next_cycle(); #1;
        n_cmp++; if (rs1_ready !== 1'b0 || rs2_ready !== 1'b0 || stall !== 1'b1) begin n_bad++; $display("FAIL pre_reset_pending got %b %b %b want 0 0 1", rs1_ready, rs2_ready, stall); end
        #1 reset = 1'b0; #1;
        n_cmp++; if (rs1_ready !== 1'b1 || rs2_ready !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ready got %b %b %b want 1 1 0", rs1_ready, rs2_ready, stall); end
        n_cmp++; if (wb_orphan !== 1'b0) begin n_bad++; $display("FAIL mid_reset_orphan got %b want 0", wb_orphan); end
        rs1_reg = 5'd7; rs2_reg = 5'd12; #1;
        n_cmp++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin n_bad++; $display("FAIL mid_reset_data got %h %h want 0 0", rs1_data, rs2_data); end
        next_cycle();
        reset = 1'b1; rs1_reg = 5'd4; rs2_reg = 5'd9;
        next_cycle(); #1;
        n_cmp++; if (rs1_ready !== 1'b1 || rs2_ready !== 1'b1 || rs1_data !== 32'h0) begin n_bad++; $display("FAIL post_reset got %b %b %h want 1 1 0", rs1_ready, rs2_ready, rs1_data); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_issue_bypass();
        test_x0();
        test_same_edge();
        test_reissue_dual();
        test_orphan();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
